mem_map_ctrl: RTL
=================

# mem_map_ctrl

Parametrised, registered memory-map controller for the pipeline processor. Decodes data-port addresses against `NUM_REGIONS` configurable windows (pixel ROM, frame RAM, sine table, …), converts them to region-local offsets, and runs a request/ready handshake that absorbs per-region read latency. It reports out-of-map and write-to-read-only accesses as errors. A separate registered instruction-fetch path serves the instruction ROM. It sits between the core's MEM/IF stages and the memory macros.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `NUM_REGIONS`, default 3: number of data regions, 1..8.
- `REGION_BASE`, default {220000, 90400, 400}: packed `NUM_REGIONS*ADDR_W`; region i occupies `[i*ADDR_W +: ADDR_W]`.
- `REGION_SIZE`, default {300, 129600, 90000}: packed like `REGION_BASE`; size in words.
- `REGION_LAT`, default {0, 1, 0}: packed `NUM_REGIONS*4`; extra read wait cycles per region, 0..15.
- `REGION_WR`, default 3'b010: bit i set means region i is writable.
- `IMEM_BASE`, default 0: instruction window base.
- `IMEM_SIZE`, default 400: instruction window size.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `d_req` in 1: data access request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: global data address.
- `d_wdata` in DATA_W: write data.
- `d_ready` out 1: one-cycle completion pulse.
- `d_err` out 1: valid with `d_ready`; access rejected.
- `d_rdata` out DATA_W: read data; held until the next completion.
- `mem_sel` out NUM_REGIONS: one-hot region select.
- `mem_we` out 1: write strobe to the selected region.
- `mem_addr` out ADDR_W: region-local offset.
- `mem_wdata` out DATA_W: write data to the region.
- `mem_rdata` in NUM_REGIONS*DATA_W: per-region read data, region i at `[i*DATA_W +: DATA_W]`.
- `if_addr` in ADDR_W: fetch address (pc).
- `if_instr` out DATA_W: registered instruction.
- `if_err` out 1: registered; fetch was outside the instruction window.
- `imem_addr` out ADDR_W: combinational, `if_addr - IMEM_BASE`.
- `imem_rdata` in DATA_W: instruction ROM data.

## Operation
- Decode: region i hits when `REGION_BASE[i] <= d_addr < REGION_BASE[i]+REGION_SIZE[i]`. The sum is evaluated at ADDR_W+1 bits, so windows reaching 2^ADDR_W do not wrap. If several regions hit, the lowest index wins.
- Offset: `d_addr - REGION_BASE[hit]`, latched at accept.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE: `d_req` is sampled only in this state.
    - On a hit with a legal operation, latch region index, offset, `d_we` and `d_wdata`, load `cnt = REGION_LAT[hit]`, and go to ACCESS.
    - On a miss, or a write to a region whose `REGION_WR` bit is 0, go straight to RESP with error.
  - ACCESS: drive `mem_sel` (one-hot), `mem_addr` and `mem_wdata` from the latched values.
    - `mem_we` is high only in the first ACCESS cycle of a write.
    - Each cycle: if `cnt != 0`, decrement; otherwise capture `mem_rdata[hit]` into `d_rdata` (reads only; writes leave `d_rdata` unchanged) and go to RESP.
  - RESP: `d_ready`=1 for exactly this cycle, with `d_err` valid. `mem_sel` is 0. Next state is IDLE.
- On error: `d_err`=1, `d_rdata` is set to 0, and no `mem_sel`/`mem_we` activity occurs.
- Requester protocol: hold `d_addr`/`d_we`/`d_wdata` stable from request until `d_ready`. Either deassert `d_req` during the `d_ready` cycle, or keep it high to present the next access, which is accepted in the following IDLE cycle.
- Fetch path, every cycle independent of the FSM:
  - `if_instr <= in-window ? imem_rdata : 0`
  - `if_err <= !in-window`
  - The window is `IMEM_BASE <= if_addr < IMEM_BASE+IMEM_SIZE`.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE. `d_ready`, `d_err`, `d_rdata`, `mem_sel`, `mem_we`, `mem_addr`, `mem_wdata`, `if_instr` and `if_err` are all 0 after that edge. `imem_addr` stays combinational.
- Reset mid-access aborts the access: no `d_ready` pulse, and `mem_we`/`mem_sel` are 0 from the next cycle.
- Legal access accepted at edge E:
  - ACCESS occupies cycles E+1 .. E+1+LAT.
  - `d_ready` is high in cycle E+2+LAT, so read latency is LAT+2 cycles.
- Error access accepted at edge E: `d_ready` and `d_err` are high in cycle E+1.
- Maximum throughput: one access per LAT+3 cycles (one per 2 cycles for errors).
- Fetch: `if_instr`/`if_err` are valid 1 cycle after `if_addr`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `d_req`=1 → all outputs 0 and no `mem_sel`. Release → the pending request is accepted on the first edge.
- ROM read: `d_addr`=400, `mem_rdata[0]`=0xCAFE0001 → `mem_sel`=001 and `mem_addr`=0 for 1 cycle, then `d_ready`=1, `d_err`=0, `d_rdata`=0xCAFE0001 two cycles after accept.
- RAM write then read:
  - Write 0x12345678 to 90405 → `mem_sel`=010, `mem_addr`=5, `mem_we` high for one cycle only, `d_ready` at +3.
  - Read 90405 → `d_ready` at +3 with the captured data.
- Errors:
  - Write to 220010 (read-only) → `d_ready` and `d_err` at +1, `mem_we` never high, `d_rdata`=0.
  - Read 220300 (just past the end) → error.
  - Read 399 → error.
- Back-to-back: `d_req` held high over reads at 220000 then 220299 → two `d_ready` pulses 3 cycles apart, `mem_addr` 0 then 299.
- Fetch: `if_addr`=396 → `if_instr`=`imem_rdata`, `if_err`=0 next cycle. `if_addr`=400 → `if_instr`=0, `if_err`=1. Both checked during a concurrent data access.

Source files
------------

// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl
//   Memory-map controller between the core's MEM/IF stages and the memory
//   macros. It decodes data addresses against NUM_REGIONS windows and turns
//   them into region-local offsets. A request/ready handshake absorbs the
//   read latency of each region. Out-of-map accesses and writes to read-only
//   regions are answered with an error. A separate registered fetch path
//   serves the instruction ROM.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   d_req/d_we/d_addr/d_wdata   data request from the MEM stage
//   d_ready/d_err/d_rdata       completion pulse, error flag, read data
//   mem_sel/mem_we/mem_addr/mem_wdata/mem_rdata   region-side access
//   if_addr/if_instr/if_err     fetch address, registered instruction/error
//   imem_addr/imem_rdata        instruction ROM address (combinational)/data
module mem_map_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'd220000, 32'd90400, 32'd400},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {32'd300, 32'd129600, 32'd90000},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_LAT  = {4'd0, 4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0]        REGION_WR   = 3'b010,
  parameter logic [ADDR_W-1:0]             IMEM_BASE   = '0,
  parameter logic [ADDR_W-1:0]             IMEM_SIZE   = 400
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic                          d_ready,
  output logic                          d_err,
  output logic [DATA_W-1:0]             d_rdata,
  output logic [NUM_REGIONS-1:0]        mem_sel,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic [DATA_W-1:0]             if_instr,
  output logic                          if_err,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [DATA_W-1:0]             imem_rdata
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_reg, state_next;

  // Per-region decode results
  logic [NUM_REGIONS-1:0] hit;
  logic [ADDR_W-1:0]      reg_off   [NUM_REGIONS];
  logic [DATA_W-1:0]      reg_rdata [NUM_REGIONS];
  logic [3:0]             reg_lat   [NUM_REGIONS];
  logic                   reg_wr    [NUM_REGIONS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      localparam logic [ADDR_W-1:0] BASE = REGION_BASE[gi*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] SIZE = REGION_SIZE[gi*ADDR_W +: ADDR_W];
      // One extra bit so a window ending exactly at 2^ADDR_W does not wrap.
      localparam logic [ADDR_W:0]   LIMIT = {1'b0, BASE} + {1'b0, SIZE};
      assign hit[gi]       = (d_addr >= BASE) && ({1'b0, d_addr} < LIMIT);
      assign reg_off[gi]   = d_addr - BASE;
      assign reg_rdata[gi] = mem_rdata[gi*DATA_W +: DATA_W];
      assign reg_lat[gi]   = REGION_LAT[gi*4 +: 4];
      assign reg_wr[gi]    = REGION_WR[gi];
    end
  endgenerate

  // Lowest-index hit wins: scan downwards so the last assignment is the lowest.
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Latched access context
  logic [IDX_W-1:0] idx_reg;
  logic             we_reg;
  logic             first_reg;
  logic             err_reg;
  logic [3:0]       cnt_reg;

  logic accept;
  logic reject;
  logic capture;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    reject     = 1'b0;
    capture    = 1'b0;
    d_ready    = 1'b0;
    d_err      = 1'b0;
    mem_sel    = '0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_req) begin
          if (hit_any && (!d_we || reg_wr[hit_idx])) begin
            accept     = 1'b1;
            state_next = ACCESS;
          end else begin
            reject     = 1'b1;
            state_next = RESP;
          end
        end
      end
      ACCESS: begin
        mem_sel = NUM_REGIONS'(1) << idx_reg;
        mem_we  = we_reg && first_reg;
        if (cnt_reg == 4'd0) begin
          capture    = !we_reg;
          state_next = RESP;
        end
      end
      RESP: begin
        d_ready    = 1'b1;
        d_err      = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      first_reg <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_rdata   <= '0;
    end else begin
      if (accept) begin
        idx_reg   <= hit_idx;
        we_reg    <= d_we;
        first_reg <= 1'b1;
        err_reg   <= 1'b0;
        cnt_reg   <= reg_lat[hit_idx];
        mem_addr  <= reg_off[hit_idx];
        mem_wdata <= d_wdata;
      end
      if (reject) begin
        err_reg <= 1'b1;
        d_rdata <= '0;
      end
      if (state_reg == ACCESS) begin
        // The write strobe belongs to the first ACCESS cycle only.
        first_reg <= 1'b0;
        if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
      end
      if (capture) d_rdata <= reg_rdata[idx_reg];
    end
  end

  // Instruction fetch path, independent of the data FSM
  localparam logic [ADDR_W:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
  logic if_in_win;
  assign if_in_win = (if_addr >= IMEM_BASE) && ({1'b0, if_addr} < IMEM_LIMIT);
  assign imem_addr = if_addr - IMEM_BASE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_instr <= '0;
      if_err   <= 1'b0;
    end else begin
      if_instr <= if_in_win ? imem_rdata : '0;
      if_err   <= !if_in_win;
    end
  end

endmodule
